// File: rtl/sim_gen_pkg.sv
// Shared defaults for the multi-channel accumulator-driven data generator.
package sim_gen_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 3;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_STEP  = 13;
  localparam int DEF_INIT  = 1;
  localparam logic [2:0] DEF_POL    = 3'b110;
  localparam logic [2:0] DEF_USE_IN = 3'b010;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;
endpackage

// File: rtl/sim_fifo.sv
// Small synchronous FIFO; head reads as zero while empty so reset never exposes stale storage.
module sim_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; validity lives entirely in the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sim_chan_gen.sv
// Accumulator-driven generator fanning out to NCH FIFO-buffered channels with global stall.
module sim_chan_gen
  import sim_gen_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter int               NCH    = DEF_NCH,
  parameter int               DEPTH  = DEF_DEPTH,
  parameter logic [WIDTH-1:0] STEP   = WIDTH'(DEF_STEP),
  parameter logic [WIDTH-1:0] INIT   = WIDTH'(DEF_INIT),
  parameter logic [NCH-1:0]   POL    = NCH'(DEF_POL),
  parameter logic [NCH-1:0]   USE_IN = NCH'(DEF_USE_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [WIDTH-1:0]       r_acc;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [NCH-1:0]         w_fire;
  logic [NCH-1:0]         w_full;
  logic [NCH-1:0]         w_empty;
  logic [NCH-1:0]         w_push;
  logic                   w_stall;
  logic                   w_step;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_fire = '0;
    for (int c = 0; c < NCH; c++)
      w_fire[c] = (r_acc[c] == POL[c]) && (!USE_IN[c] || in_valid);
  end

  // Full is the registered occupancy, so a pop in the same cycle cannot release a stall.
  assign w_stall   = en && |(w_fire & w_full);
  assign w_step    = en && !w_stall && reset;
  assign w_push    = w_fire & {NCH{w_step}};
  assign in_ready  = w_step;
  assign out_valid = ~w_empty;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= INIT;
      r_stall_cnt <= '0;
    end else begin
      if (w_step)  r_acc       <= r_acc + STEP;
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [WIDTH-1:0] w_wdata;
    assign w_wdata = r_acc + (USE_IN[g] ? in_a : '0) + WIDTH'(g);

    sim_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[g]),
      .wdata (w_wdata),
      .pop   (out_ready[g]),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .head  (out_data[g*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_sim_chan_gen.sv
// Scoreboard bench: a cycle model queues expected channel words, popped as the DUT drains them.
module tb_sim_chan_gen;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [95:0] out_data;
  logic [15:0] stall_cnt;

  logic        reset_w;
  logic        en_w;
  logic        in_valid_w;
  logic        in_ready_w;
  logic [31:0] in_a_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  out_ready_w;
  logic [95:0] out_data_w;
  logic [15:0] stall_cnt_w;

  sim_chan_gen u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  sim_chan_gen #(.INIT(32'hFFFF_FFF8)) u_dut_wrap (
    .clk       (clk),
    .reset     (reset_w),
    .en        (en_w),
    .in_valid  (in_valid_w),
    .in_ready  (in_ready_w),
    .in_a      (in_a_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .out_data  (out_data_w),
    .stall_cnt (stall_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] m_acc;
  int          m_stall;
  logic [2:0]  pol_m;
  logic [2:0]  use_m;
  logic [31:0] sbq [3][$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: compare, update the model, then cross a rising edge and land on the falling edge.
  task automatic tick();
    logic [2:0]  fire;
    logic [2:0]  full;
    logic        stall;
    logic        step;
    logic [31:0] exp;
    #1;
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    for (int c = 0; c < 3; c++) begin
      fire[c] = (m_acc[c] == pol_m[c]) && (!use_m[c] || in_valid);
      full[c] = (sbq[c].size() == DEPTH);
    end
    stall = en && |(fire & full);
    step  = en && !stall;
    chk("in_ready", 32'(in_ready), 32'(step));
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("valid%0d", c), 32'(out_valid[c]), (sbq[c].size() != 0) ? 32'd1 : 32'd0);
      if (sbq[c].size() != 0 && out_ready[c]) begin
        exp = sbq[c].pop_front();
        chk($sformatf("data%0d", c), out_data[c*32 +: 32], exp);
      end
    end
    for (int c = 0; c < 3; c++)
      if (step && fire[c]) sbq[c].push_back(m_acc + (use_m[c] ? in_a : 32'd0) + 32'(c));
    if (step) m_acc = m_acc + 32'd13;
    if (stall && m_stall < 65535) m_stall++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks the immediate effect, releases on a falling edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_data_lo", out_data[31:0], 32'd0);
    for (int c = 0; c < 3; c++) sbq[c].delete();
    m_acc   = 32'd1;
    m_stall = 0;
    @(negedge clk);
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    pol_m     = 3'b110;
    use_m     = 3'b010;
    m_acc     = 32'd1;
    m_stall   = 0;
    reset     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    out_ready = 3'b111;
    reset_w     = 1'b0;
    en_w        = 1'b0;
    in_valid_w  = 1'b0;
    in_a_w      = 32'd0;
    out_ready_w = 3'b111;

    repeat (2) @(negedge clk);
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_data", out_data[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("init_stall", 32'(stall_cnt), 32'd0);
    chk("init_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;

    // Free-running, no input: acc 1,14,27,40
    tick();
    tick();
    chk("s1_ch0_14", out_data[31:0], 32'd14);
    chk("s1_ch2_16", out_data[95:64], 32'd16);
    chk("s1_ch1_quiet", 32'(out_valid[1]), 32'd0);
    repeat (3) tick();

    // Input consumed by channel 1 at acc=14
    do_reset();
    tick();
    in_valid = 1'b1;
    in_a     = 32'd100;
    tick();
    in_valid = 1'b0;
    chk("s2_ch1_valid", 32'(out_valid[1]), 32'd1);
    chk("s2_ch1_115", out_data[63:32], 32'd115);
    repeat (2) tick();

    // Back-pressure on channel 0 until stall, then saturate the stall counter
    do_reset();
    out_ready = 3'b110;
    repeat (12) tick();
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m_stall = (m_stall + 65540 > 65535) ? 65535 : m_stall + 65540;
    chk("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    tick();
    out_ready = 3'b111;
    tick();
    tick();
    out_ready = 3'b110;
    repeat (3) tick();

    // Asynchronous reset with data pending
    chk("s4_pending", 32'(out_valid[0]), 32'd1);
    do_reset();

    // Accumulate, then disable and drain
    out_ready = 3'b000;
    repeat (4) tick();
    en       = 1'b0;
    in_valid = 1'b1;
    in_a     = 32'd5;
    out_ready = 3'b111;
    repeat (5) tick();
    chk("s5_drained", 32'(out_valid), 32'd0);
    en       = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();

    // Accumulator wrap: INIT=FFFF_FFF8 steps to 5
    reset_w = 1'b1;
    en_w    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wrap_ch0_valid", 32'(out_valid_w[0]), 32'd1);
    chk("wrap_ch0_data", out_data_w[31:0], 32'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_ch2_valid", 32'(out_valid_w[2]), 32'd1);
    chk("wrap_ch2_data", out_data_w[95:64], 32'd7);
    chk("wrap_ch0_empty", 32'(out_valid_w[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
